// File: rtl/ds_tos_cache.sv
// ds_tos_cache: register cache for the top two data-stack cells (TOS, NOS).
// Forth stack ops run in one cycle. Cells spill from NOS into the EBR stack
// below, and NOS refills from it after a one-cycle bubble.
// Optional feature macro: DS_HIWATER_EN adds a `hiwater` peak-depth output.
module ds_tos_cache #(
   parameter int DEPTH = 64,
   parameter int DSZ   = 32,
   parameter int CSZ   = $clog2(DEPTH + 3)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_vld,
   output logic           req_rdy,
   input  logic [2:0]     req_op,
   input  logic [DSZ-1:0] din,
   output logic [DSZ-1:0] tos,
   output logic [DSZ-1:0] nos,
   output logic [CSZ-1:0] depth,
   output logic           err_ovf,
   output logic           err_udf,
   output logic           ss_en,
   output logic [1:0]     ss_op,
   output logic [DSZ-1:0] ss_vi,
   input  logic [DSZ-1:0] ss_s
`ifdef DS_HIWATER_EN
   ,
   output logic [CSZ-1:0] hiwater
`endif
);

   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_DUP  = 3'd3;
   localparam logic [2:0] OP_SWAP = 3'd4;
   localparam logic [2:0] OP_OVER = 3'd5;
   localparam logic [2:0] OP_REPL = 3'd6;

   localparam logic [1:0] SS_NOP  = 2'd0;
   localparam logic [1:0] SS_PUSH = 2'd1;
   localparam logic [1:0] SS_POP  = 2'd2;

   localparam logic [CSZ-1:0] FULL = CSZ'(DEPTH + 2);

   typedef enum logic {ST_RUN, ST_FILL} state_t;

   state_t         state_reg, state_next;
   logic [DSZ-1:0] tos_reg, tos_next;
   logic [DSZ-1:0] nos_reg, nos_next;
   logic [CSZ-1:0] depth_reg, depth_next;
   logic           err_ovf_reg, err_udf_reg;

   logic accept;
   logic d_ge1, d_ge2, d_gt2, d_full;
   logic grow, shrink, ovf_hit, udf_hit, op_ok;
   logic spill, fetch;

   assign accept = req_vld && req_rdy;
   assign d_ge1  = (depth_reg != '0);
   assign d_ge2  = (depth_reg >= CSZ'(2));
   assign d_gt2  = (depth_reg >  CSZ'(2));
   assign d_full = (depth_reg == FULL);

   // Classify the accepted op: does it grow/shrink the stack, or is it refused
   always_comb begin
      grow    = 1'b0;
      shrink  = 1'b0;
      ovf_hit = 1'b0;
      udf_hit = 1'b0;
      if (accept) begin
         case (req_op)
            OP_PUSH: if (d_full) ovf_hit = 1'b1; else grow = 1'b1;
            OP_POP:  if (!d_ge1) udf_hit = 1'b1; else shrink = 1'b1;
            OP_DUP: begin
               if (!d_ge1)      udf_hit = 1'b1;
               else if (d_full) ovf_hit = 1'b1;
               else             grow    = 1'b1;
            end
            OP_SWAP: if (!d_ge2) udf_hit = 1'b1;
            OP_OVER: begin
               if (!d_ge2)      udf_hit = 1'b1;
               else if (d_full) ovf_hit = 1'b1;
               else             grow    = 1'b1;
            end
            OP_REPL: if (!d_ge1) udf_hit = 1'b1;
            default: ;
         endcase
      end
   end

   assign op_ok = accept && !ovf_hit && !udf_hit;
   // A growing op pushes old NOS below once NOS holds a live cell;
   // a shrinking op pulls a cell up only while the EBR holds one.
   assign spill = grow && d_ge2;
   assign fetch = shrink && d_gt2;

   // Next-state logic: a POP that empties a cell from the EBR costs a refill cycle
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:  if (fetch) state_next = ST_FILL;
         ST_FILL: state_next = ST_RUN;
         default: state_next = ST_RUN;
      endcase
   end

   // FSM outputs: handshake and the EBR command bus
   always_comb begin
      req_rdy = (state_reg == ST_RUN);
      ss_op   = SS_NOP;
      if (spill)      ss_op = SS_PUSH;
      else if (fetch) ss_op = SS_POP;
      ss_en   = spill || fetch;
      ss_vi   = nos_reg;
   end

   // Datapath: next TOS/NOS/depth for the accepted op or the refill cycle
   always_comb begin
      tos_next   = tos_reg;
      nos_next   = nos_reg;
      depth_next = depth_reg;
      if (state_reg == ST_FILL) begin
         nos_next = ss_s;
      end else if (op_ok) begin
         case (req_op)
            OP_PUSH: begin
               nos_next = tos_reg;
               tos_next = din;
            end
            OP_POP: begin
               tos_next = nos_reg;
               if (!d_gt2) nos_next = '0;
            end
            OP_DUP:  nos_next = tos_reg;
            OP_SWAP, OP_OVER: begin
               tos_next = nos_reg;
               nos_next = tos_reg;
            end
            OP_REPL: tos_next = din;
            default: ;
         endcase
         if (grow)   depth_next = depth_reg + CSZ'(1);
         if (shrink) depth_next = depth_reg - CSZ'(1);
      end
   end

   // State and datapath registers; errors are sticky until reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_RUN;
         tos_reg     <= '0;
         nos_reg     <= '0;
         depth_reg   <= '0;
         err_ovf_reg <= 1'b0;
         err_udf_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tos_reg     <= tos_next;
         nos_reg     <= nos_next;
         depth_reg   <= depth_next;
         err_ovf_reg <= err_ovf_reg | ovf_hit;
         err_udf_reg <= err_udf_reg | udf_hit;
      end
   end

   assign tos     = tos_reg;
   assign nos     = nos_reg;
   assign depth   = depth_reg;
   assign err_ovf = err_ovf_reg;
   assign err_udf = err_udf_reg;

`ifdef DS_HIWATER_EN
   logic [CSZ-1:0] hiwater_reg;

   // Peak depth, following the depth register one cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       hiwater_reg <= '0;
      else if (depth_reg > hiwater_reg) hiwater_reg <= depth_reg;
   end

   assign hiwater = hiwater_reg;
`endif

endmodule

// File: tb/tb_ds_tos_cache.sv
// tb_ds_tos_cache: directed scenarios plus randomized op streams checked
// against a queue-based model of the whole data stack and of the EBR stack.
module tb_ds_tos_cache;
   localparam int DEPTH = 8;
   localparam int DSZ   = 32;
   localparam int CSZ   = $clog2(DEPTH + 3);
   localparam int FULL  = DEPTH + 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_vld = 1'b0;
   logic           req_rdy;
   logic [2:0]     req_op = 3'd0;
   logic [DSZ-1:0] din = '0;
   logic [DSZ-1:0] tos, nos;
   logic [CSZ-1:0] depth;
   logic           err_ovf, err_udf;
   logic           ss_en;
   logic [1:0]     ss_op;
   logic [DSZ-1:0] ss_vi;
   logic [DSZ-1:0] ss_s;
`ifdef DS_HIWATER_EN
   logic [CSZ-1:0] hiwater;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model: whole stack, top at the back
   logic [DSZ-1:0] mq[$];
   logic           m_ovf = 1'b0, m_udf = 1'b0;
   int             hw_exp = 0;
   // EBR stack emulation driven by the DUT bus
   logic [DSZ-1:0] ebr[$];

   ds_tos_cache #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .din(din),
      .tos(tos), .nos(nos), .depth(depth),
      .err_ovf(err_ovf), .err_udf(err_udf),
      .ss_en(ss_en), .ss_op(ss_op), .ss_vi(ss_vi), .ss_s(ss_s)
`ifdef DS_HIWATER_EN
      , .hiwater(hiwater)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ebr.delete();
         ss_s <= '0;
      end else if (ss_en) begin
         if (ss_op == 2'd1) ebr.push_back(ss_vi);
         else if (ss_op == 2'd2 && ebr.size() > 0) ss_s <= ebr.pop_back();
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DSZ-1:0] m_tos();
      return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
   endfunction

   function automatic logic [DSZ-1:0] m_nos();
      return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
   endfunction

   task automatic chk_state(input string tag);
      int n = mq.size();
      chk({tag, "_tos"}, tos, m_tos());
      chk({tag, "_nos"}, nos, m_nos());
      chk({tag, "_depth"}, depth, n);
      chk({tag, "_ovf"}, err_ovf, m_ovf);
      chk({tag, "_udf"}, err_udf, m_udf);
      chk({tag, "_ebr_n"}, ebr.size(), (n > 2) ? n - 2 : 0);
`ifdef DS_HIWATER_EN
      chk({tag, "_hiwater"}, hiwater, hw_exp);
`endif
   endtask

   // called at a negedge; leaves at a negedge
   task automatic do_reset();
      req_vld = 1'b0;
      rst = 1'b0;
      #1;
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; hw_exp = 0;
      chk("rst_tos", tos, 0);
      chk("rst_nos", nos, 0);
      chk("rst_depth", depth, 0);
      chk("rst_ovf", err_ovf, 0);
      chk("rst_udf", err_udf, 0);
      chk("rst_rdy", req_rdy, 1);
      chk("rst_ss_en", ss_en, 0);
      chk("rst_ss_op", ss_op, 0);
`ifdef DS_HIWATER_EN
      chk("rst_hiwater", hiwater, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   // one accepted op (or an idle cycle when vld=0); starts and ends on a negedge
   task automatic step(input logic vld, input logic [2:0] op, input logic [DSZ-1:0] val);
      int n = mq.size();
      bit spill = 0, fetch = 0;
      logic [DSZ-1:0] vi = '0;
      logic [DSZ-1:0] t;
      req_vld = vld; req_op = op; din = val;
      #1;
      chk("rdy", req_rdy, 1);
      if (vld) begin
         case (op)
            3'd1: if (n == FULL) m_ovf = 1'b1;
                  else begin
                     if (n >= 2) begin spill = 1; vi = mq[n-2]; end
                     mq.push_back(val);
                  end
            3'd2: if (n == 0) m_udf = 1'b1;
                  else begin
                     fetch = (n > 2);
                     t = mq.pop_back();
                  end
            3'd3: if (n == 0) m_udf = 1'b1;
                  else if (n == FULL) m_ovf = 1'b1;
                  else begin
                     if (n >= 2) begin spill = 1; vi = mq[n-2]; end
                     mq.push_back(mq[n-1]);
                  end
            3'd4: if (n < 2) m_udf = 1'b1;
                  else begin
                     t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t;
                  end
            3'd5: if (n < 2) m_udf = 1'b1;
                  else if (n == FULL) m_ovf = 1'b1;
                  else begin
                     spill = 1; vi = mq[n-2];
                     mq.push_back(mq[n-2]);
                  end
            3'd6: if (n == 0) m_udf = 1'b1;
                  else mq[n-1] = val;
            default: ;
         endcase
      end
      chk("ss_en", ss_en, spill | fetch);
      chk("ss_op", ss_op, spill ? 2'd1 : (fetch ? 2'd2 : 2'd0));
      if (spill) chk("ss_vi", ss_vi, vi);
      if (n > hw_exp) hw_exp = n;
      @(posedge clk);
      @(negedge clk);
      if (fetch) begin
         // refill bubble: a pending request must be held off
         req_vld = 1'b1; req_op = 3'd1; din = $urandom;
         #1;
         chk("fill_rdy", req_rdy, 0);
         chk("fill_ss_en", ss_en, 0);
         if (mq.size() > hw_exp) hw_exp = mq.size();
         @(posedge clk);
         @(negedge clk);
      end
      req_vld = 1'b0;
      #1;
      chk_state(fetch ? "fill" : "op");
   endtask

   initial begin
      logic [2:0] op;
      @(negedge clk);
      do_reset();

      // back-to-back pushes, spill on the third
      step(1, 3'd1, 1); step(1, 3'd1, 2); step(1, 3'd1, 3);
      chk("t1_tos", tos, 3); chk("t1_nos", nos, 2); chk("t1_depth", depth, 3);
      // POP with refill, then POP without
      step(1, 3'd2, 0);
      chk("t2_nos", nos, 1); chk("t2_depth", depth, 2);
      step(1, 3'd2, 0);
      chk("t2b_tos", tos, 1); chk("t2b_nos", nos, 0); chk("t2b_depth", depth, 1);
      step(1, 3'd2, 0);
      // SWAP / OVER from empty
      step(1, 3'd1, 5); step(1, 3'd1, 7); step(1, 3'd4, 0);
      chk("t3_tos", tos, 5); chk("t3_nos", nos, 7);
      step(1, 3'd5, 0);
      chk("t3b_tos", tos, 7); chk("t3b_nos", nos, 5); chk("t3b_depth", depth, 3);
      // fill to capacity, then overflow
      while (mq.size() < FULL) step(1, 3'd1, $urandom);
      step(1, 3'd1, 9);
      chk("t4_ovf", err_ovf, 1); chk("t4_depth", depth, FULL);
      step(1, 3'd3, 0); step(1, 3'd5, 0);
      // drain everything through the EBR
      while (mq.size() > 0) step(1, 3'd2, 0);
      // underflow cases
      do_reset();
      step(1, 3'd2, 0);
      chk("t5_udf", err_udf, 1); chk("t5_depth", depth, 0);
      step(1, 3'd3, 0); step(1, 3'd6, 4);
      step(1, 3'd1, 11); step(1, 3'd4, 0); step(1, 3'd5, 0);
      chk("t5b_tos", tos, 11);
      // reset during the refill bubble
      do_reset();
      step(1, 3'd1, 21); step(1, 3'd1, 22); step(1, 3'd1, 23); step(1, 3'd1, 24);
      req_vld = 1'b1; req_op = 3'd2;
      @(posedge clk);
      @(negedge clk);
      req_vld = 1'b0;
      #1;
      chk("t6_fill_rdy", req_rdy, 0);
      rst = 1'b0;
      #1;
      chk("t6_tos", tos, 0); chk("t6_nos", nos, 0);
      chk("t6_depth", depth, 0); chk("t6_rdy", req_rdy, 1);
`ifdef DS_HIWATER_EN
      chk("t6_hiwater", hiwater, 0);
`endif
      @(negedge clk);
      do_reset();

      // randomized streams, alternating push-biased and pop-biased phases
      for (int i = 0; i < 900; i++) begin
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) op = ((i / 60) % 2 == 0) ? 3'd1 : 3'd2;
         if (i % 300 == 299) do_reset();
         step(($urandom_range(0, 7) != 0), op, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
